// File: rtl/flag_resolve_pkg.sv
// Shared encodings for flag_resolve: resolve kinds and buffer occupancy states.
package flag_resolve_pkg;

    // Resolve kinds, matching the decoder's opcode table.
    localparam logic [3:0] KIND_PASS = 4'd0;
    localparam logic [3:0] KIND_SEQ  = 4'd1;
    localparam logic [3:0] KIND_SLT  = 4'd2;
    localparam logic [3:0] KIND_SLE  = 4'd3;
    localparam logic [3:0] KIND_SCO  = 4'd4;
    localparam logic [3:0] KIND_BEQZ = 4'd5;
    localparam logic [3:0] KIND_BNEZ = 4'd6;
    localparam logic [3:0] KIND_BLTZ = 4'd7;
    localparam logic [3:0] KIND_BGEZ = 4'd8;

    // Buffer occupancy states.
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    // Encodings above BGEZ are reserved.
    function automatic logic kind_is_reserved(input logic [3:0] kind);
        return kind > KIND_BGEZ;
    endfunction

endpackage

// File: rtl/flag_resolve_cond_eval.sv
// Combinational resolver: kind + ALU flags/output -> writeback value and branch decision.
module cond_eval
    import flag_resolve_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       kind,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             zf,
    input  logic             sf,
    input  logic             cf,
    input  logic             of,
    output logic [WIDTH-1:0] result,
    output logic             is_branch,
    output logic             taken,
    output logic             bad
);

    // Decode the kind; set-type kinds collapse their condition into bit 0.
    always_comb begin
        result    = alu_out;
        is_branch = 1'b0;
        taken     = 1'b0;
        bad       = kind_is_reserved(kind);
        case (kind)
            KIND_SEQ:  result = {{(WIDTH-1){1'b0}}, zf};
            KIND_SLT:  result = {{(WIDTH-1){1'b0}}, sf ^ of};
            KIND_SLE:  result = {{(WIDTH-1){1'b0}}, (sf ^ of) | zf};
            KIND_SCO:  result = {{(WIDTH-1){1'b0}}, cf};
            KIND_BEQZ: begin is_branch = 1'b1; taken = zf;  end
            KIND_BNEZ: begin is_branch = 1'b1; taken = ~zf; end
            KIND_BLTZ: begin is_branch = 1'b1; taken = sf;  end
            KIND_BGEZ: begin is_branch = 1'b1; taken = ~sf; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/flag_resolve.sv
// Execute-stage flag resolver with a 2-entry skid buffer toward writeback/PC-select.
module flag_resolve
    import flag_resolve_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_kind,
    input  logic [WIDTH-1:0] in_alu_out,
    input  logic             in_zf,
    input  logic             in_sf,
    input  logic             in_cf,
    input  logic             in_of,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_is_branch,
    output logic             out_taken,
    output logic [3:0]       flags_q,
    output logic             bad_kind
);

    logic [WIDTH-1:0] ce_result;
    logic             ce_is_branch;
    logic             ce_taken;
    logic             ce_bad;

    cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
        .kind      (in_kind),
        .alu_out   (in_alu_out),
        .zf        (in_zf),
        .sf        (in_sf),
        .cf        (in_cf),
        .of        (in_of),
        .result    (ce_result),
        .is_branch (ce_is_branch),
        .taken     (ce_taken),
        .bad       (ce_bad)
    );

    logic [1:0]       count_q,  count_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0] slot_result_q [DEPTH];
    logic [WIDTH-1:0] slot_result_d [DEPTH];
    logic             slot_branch_q [DEPTH];
    logic             slot_branch_d [DEPTH];
    logic             slot_taken_q  [DEPTH];
    logic             slot_taken_d  [DEPTH];
    logic [3:0]       flags_d;
    logic             bad_kind_q, bad_kind_d;
    logic             push;
    logic             pop;

    // Handshake and outputs come only from registered state.
    assign in_ready      = (count_q != CNT_FULL);
    assign out_valid     = (count_q != CNT_EMPTY);
    assign out_result    = slot_result_q[rd_ptr_q];
    assign out_is_branch = slot_branch_q[rd_ptr_q];
    assign out_taken     = slot_taken_q[rd_ptr_q];
    assign bad_kind      = bad_kind_q;
    assign push          = in_valid & in_ready;
    assign pop           = out_valid & out_ready;

    // Next-state: occupancy, pointers, slot writes, flags and sticky error.
    always_comb begin
        count_d = count_q;
        case (count_q)
            CNT_EMPTY: if (push)         count_d = CNT_ONE;
            CNT_ONE:   if (push && !pop) count_d = CNT_FULL;
                       else if (!push && pop) count_d = CNT_EMPTY;
            CNT_FULL:  if (pop)          count_d = CNT_ONE;
            default:                     count_d = CNT_EMPTY;
        endcase

        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;

        slot_result_d = slot_result_q;
        slot_branch_d = slot_branch_q;
        slot_taken_d  = slot_taken_q;
        if (push) begin
            slot_result_d[wr_ptr_q] = ce_result;
            slot_branch_d[wr_ptr_q] = ce_is_branch;
            slot_taken_d[wr_ptr_q]  = ce_taken;
        end

        flags_d    = push ? {in_zf, in_sf, in_cf, in_of} : flags_q;
        bad_kind_d = bad_kind_q | (push & ce_bad);
    end

    // State registers; reset drops any buffered entries immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= CNT_EMPTY;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            slot_result_q <= '{default: '0};
            slot_branch_q <= '{default: 1'b0};
            slot_taken_q  <= '{default: 1'b0};
            flags_q       <= '0;
            bad_kind_q    <= 1'b0;
        end else begin
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            slot_result_q <= slot_result_d;
            slot_branch_q <= slot_branch_d;
            slot_taken_q  <= slot_taken_d;
            flags_q       <= flags_d;
            bad_kind_q    <= bad_kind_d;
        end
    end

endmodule

// File: tb/tb_flag_resolve.sv
// Directed + random bench for flag_resolve with a result scoreboard.
module tb_flag_resolve;

    typedef struct packed {
        logic [15:0] result;
        logic        is_branch;
        logic        taken;
        logic        bad;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_kind = '0;
    logic [15:0] in_alu_out = '0;
    logic        in_zf = 1'b0, in_sf = 1'b0, in_cf = 1'b0, in_of = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic        out_is_branch;
    logic        out_taken;
    logic [3:0]  flags_q;
    logic        bad_kind;

    flag_resolve #(.WIDTH(16), .DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_kind       (in_kind),
        .in_alu_out    (in_alu_out),
        .in_zf         (in_zf),
        .in_sf         (in_sf),
        .in_cf         (in_cf),
        .in_of         (in_of),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_is_branch (out_is_branch),
        .out_taken     (out_taken),
        .flags_q       (flags_q),
        .bad_kind      (bad_kind)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];
    int   m_count = 0;
    logic [3:0] m_flags = '0;
    logic m_bad = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Reference resolution taken straight from the kind table.
    function automatic exp_t model(input logic [3:0] k, input logic [15:0] a, input logic [3:0] f);
        logic z, s, c, o;
        exp_t e;
        {z, s, c, o} = f;
        e = '{result: a, is_branch: 1'b0, taken: 1'b0, bad: 1'b0};
        case (k)
            4'd0: ;
            4'd1: e.result = z ? 16'h0001 : 16'h0000;
            4'd2: e.result = (s != o) ? 16'h0001 : 16'h0000;
            4'd3: e.result = ((s != o) || z) ? 16'h0001 : 16'h0000;
            4'd4: e.result = c ? 16'h0001 : 16'h0000;
            4'd5: begin e.is_branch = 1'b1; e.taken = z;  end
            4'd6: begin e.is_branch = 1'b1; e.taken = !z; end
            4'd7: begin e.is_branch = 1'b1; e.taken = s;  end
            4'd8: begin e.is_branch = 1'b1; e.taken = !s; end
            default: e.bad = 1'b1;
        endcase
        return e;
    endfunction

    // One clock cycle: drive after negedge, check just before posedge, update model at the edge.
    task automatic cyc(input logic v, input logic [3:0] k, input logic [15:0] a,
                       input logic [3:0] f, input logic ordy);
        exp_t e;
        logic do_push, do_pop;
        @(negedge clk);
        in_valid = v; in_kind = k; in_alu_out = a;
        {in_zf, in_sf, in_cf, in_of} = f;
        out_ready = ordy;
        #4;
        do_push = v && (m_count != 2);
        do_pop  = (m_count != 0) && ordy;
        chk("in_ready",  in_ready,  (m_count != 2));
        chk("out_valid", out_valid, (m_count != 0));
        chk("flags_q",   flags_q,   m_flags);
        chk("bad_kind",  bad_kind,  m_bad);
        if (do_pop) begin
            e = sb.pop_front();
            chk("out_result",    out_result,    e.result);
            chk("out_is_branch", out_is_branch, e.is_branch);
            chk("out_taken",     out_taken,     e.taken);
        end
        @(posedge clk);
        if (do_push) begin
            e = model(k, a, f);
            sb.push_back(e);
            m_flags = f;
            m_bad = m_bad | e.bad;
        end
        m_count = m_count + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_result",    out_result, 16'h0000);
        chk("rst_branch",    out_is_branch, 1'b0);
        chk("rst_taken",     out_taken, 1'b0);
        chk("rst_flags",     flags_q, 4'b0000);
        chk("rst_bad",       bad_kind, 1'b0);
        rst_n = 1'b1;

        // SLT signed: SF=1 OF=0 -> 1, then SF=1 OF=1 -> 0 (pushed while first pops)
        cyc(1, 4'd2, 16'hFFFE, 4'b0100, 1);
        cyc(1, 4'd2, 16'h7FFF, 4'b0101, 1);
        cyc(0, 4'd0, 16'h0000, 4'b0000, 1);

        // BNEZ with ZF=0 -> taken, result passes through, flags all clear
        cyc(1, 4'd6, 16'h1234, 4'b0000, 1);
        cyc(0, 4'd0, 16'h0000, 4'b0000, 1);

        // Fill and stall, third push dropped, then drain in order
        cyc(1, 4'd1, 16'h5555, 4'b1000, 0);
        cyc(1, 4'd0, 16'hBEEF, 4'b0010, 0);
        cyc(1, 4'd0, 16'hDEAD, 4'b0001, 0);
        cyc(0, 4'd0, 16'h0000, 4'b0000, 0);
        cyc(0, 4'd0, 16'h0000, 4'b0000, 1);
        cyc(0, 4'd0, 16'h0000, 4'b0000, 1);
        cyc(0, 4'd0, 16'h0000, 4'b0000, 1);

        // Back-to-back push/pop at count 1
        cyc(1, 4'd0, 16'h0001, 4'b0000, 1);
        cyc(1, 4'd0, 16'h0002, 4'b0000, 1);
        cyc(1, 4'd0, 16'h0003, 4'b0000, 1);
        cyc(0, 4'd0, 16'h0000, 4'b0000, 1);

        // Remaining kinds
        cyc(1, 4'd3, 16'h0000, 4'b1000, 1);
        cyc(1, 4'd3, 16'h0001, 4'b0000, 1);
        cyc(1, 4'd4, 16'h0003, 4'b0010, 1);
        cyc(1, 4'd5, 16'h0000, 4'b1000, 1);
        cyc(1, 4'd5, 16'h0009, 4'b0000, 1);
        cyc(1, 4'd7, 16'h8000, 4'b0100, 1);
        cyc(1, 4'd8, 16'h8001, 4'b0100, 1);
        cyc(1, 4'd8, 16'h0001, 4'b0000, 1);
        cyc(0, 4'd0, 16'h0000, 4'b0000, 1);

        // Reserved kind: passes through, sets sticky bad_kind
        cyc(1, 4'd12, 16'h00FF, 4'b0110, 1);
        cyc(0, 4'd0, 16'h0000, 4'b0000, 1);
        cyc(0, 4'd0, 16'h0000, 4'b0000, 1);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                4'($urandom), 1'($urandom_range(0, 1)));
        end

        // Async reset with two entries buffered
        cyc(1, 4'd0, 16'hAAAA, 4'b1111, 0);
        cyc(1, 4'd0, 16'hBBBB, 4'b1111, 0);
        cyc(1, 4'd12, 16'hCCCC, 4'b1111, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready",  in_ready,  1'b1);
        chk("arst_flags",     flags_q,   4'b0000);
        chk("arst_bad",       bad_kind,  1'b0);
        sb.delete();
        m_count = 0; m_flags = '0; m_bad = 1'b0;
        #1 rst_n = 1'b1;

        // Post-reset traffic
        cyc(1, 4'd1, 16'h0000, 4'b0000, 1);
        cyc(0, 4'd0, 16'h0000, 4'b0000, 1);

        // Drain whatever remains, bounded
        for (int i = 0; i < 4 && m_count != 0; i++) cyc(0, 4'd0, 16'h0000, 4'b0000, 1);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
